// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for an MCP4921-class DAC: captures a 12-bit code per strobe,
// shifts out {DAC_CFG, code}, pulses LDAC, and keeps one newest-wins pending sample.
module dac_spi_tx #(
  parameter int          CLK_DIV = 4,
  parameter logic [3:0]  DAC_CFG = 4'b0111,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [11:0]      sample_data,
  output logic             dac_sclk,
  output logic             dac_cs_n,
  output logic             dac_mosi,
  output logic             dac_ldac_n,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] drop_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, CS_GAP, LDAC} state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [3:0]       bit_reg;
  logic [15:0]      shift_reg;
  logic             pend_valid_reg;
  logic [11:0]      pend_data_reg;
  logic             sclk_reg;
  logic             cs_n_reg;
  logic             ldac_n_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CNT_W-1:0] drop_reg;

  logic             start_frame;
  logic [11:0]      start_data;

  // A frame starts from IDLE, or back-to-back on LDAC exit when a sample is pending.
  always_comb begin
    start_frame = 1'b0;
    start_data  = pend_data_reg;
    if (state_reg == IDLE) begin
      start_frame = pend_valid_reg || sample_valid;
      start_data  = pend_valid_reg ? pend_data_reg : sample_data;
    end else if (state_reg == LDAC && div_reg == '0 && pend_valid_reg) begin
      start_frame = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      div_reg        <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= '0;
      sclk_reg       <= 1'b0;
      cs_n_reg       <= 1'b1;
      ldac_n_reg     <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      drop_reg       <= '0;
    end else begin
      done_reg <= 1'b0;

      // Strobes during a frame (including the LDAC exit cycle) go to the pending slot.
      if (busy_reg && sample_valid) begin
        pend_valid_reg <= 1'b1;
        pend_data_reg  <= sample_data;
        if (pend_valid_reg && drop_reg != '1)
          drop_reg <= drop_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (pend_valid_reg) begin
            if (sample_valid) pend_data_reg  <= sample_data;
            else              pend_valid_reg <= 1'b0;
          end
        end
        SETUP, SCK_LO: begin
          if (div_reg == '0) begin
            state_reg <= SCK_HI;
            div_reg   <= DIV_LOAD;
            sclk_reg  <= 1'b1;
          end else begin
            div_reg <= div_reg - 1'b1;
          end
        end
        SCK_HI: begin
          if (div_reg == '0) begin
            div_reg   <= DIV_LOAD;
            sclk_reg  <= 1'b0;
            // After the 16th shift the register is all zeros, so MOSI idles low.
            shift_reg <= {shift_reg[14:0], 1'b0};
            if (bit_reg == '0) begin
              state_reg <= CS_GAP;
              cs_n_reg  <= 1'b1;
            end else begin
              state_reg <= SCK_LO;
              bit_reg   <= bit_reg - 1'b1;
            end
          end else begin
            div_reg <= div_reg - 1'b1;
          end
        end
        CS_GAP: begin
          if (div_reg == '0) begin
            state_reg  <= LDAC;
            div_reg    <= DIV_LOAD;
            ldac_n_reg <= 1'b0;
          end else begin
            div_reg <= div_reg - 1'b1;
          end
        end
        LDAC: begin
          if (div_reg == '0) begin
            ldac_n_reg <= 1'b1;
            done_reg   <= 1'b1;
            if (!pend_valid_reg) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else if (!sample_valid) begin
              pend_valid_reg <= 1'b0;
            end
          end else begin
            div_reg <= div_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (start_frame) begin
        state_reg <= SETUP;
        div_reg   <= DIV_LOAD;
        bit_reg   <= 4'd15;
        shift_reg <= {DAC_CFG, start_data};
        cs_n_reg  <= 1'b0;
        sclk_reg  <= 1'b0;
        busy_reg  <= 1'b1;
      end
    end
  end

  assign dac_sclk   = sclk_reg;
  assign dac_cs_n   = cs_n_reg;
  assign dac_mosi   = shift_reg[15];
  assign dac_ldac_n = ldac_n_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: pin-level SPI capture monitors plus a frame-level reference
// model (fixed-length busy window, one newest-wins pending slot) for random strobes.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT a: CLK_DIV=4, 4-bit drop counter; DUT b: CLK_DIV=1
  logic        a_sv = 1'b0, b_sv = 1'b0;
  logic [11:0] a_sd = '0, b_sd = '0;
  logic        a_sclk, a_cs_n, a_mosi, a_ldac_n, a_busy, a_done;
  logic [3:0]  a_drop;
  logic        b_sclk, b_cs_n, b_mosi, b_ldac_n, b_busy, b_done;
  logic [15:0] b_drop;

  dac_spi_tx #(.CLK_DIV(4), .DAC_CFG(4'b0111), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .sample_valid(a_sv), .sample_data(a_sd),
    .dac_sclk(a_sclk), .dac_cs_n(a_cs_n), .dac_mosi(a_mosi), .dac_ldac_n(a_ldac_n),
    .busy(a_busy), .frame_done(a_done), .drop_count(a_drop));

  dac_spi_tx #(.CLK_DIV(1), .DAC_CFG(4'b0111), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .sample_valid(b_sv), .sample_data(b_sd),
    .dac_sclk(b_sclk), .dac_cs_n(b_cs_n), .dac_mosi(b_mosi), .dac_ldac_n(b_ldac_n),
    .busy(b_busy), .frame_done(b_done), .drop_count(b_drop));

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Pin-level monitors, sampled on the falling edge; cleared while rst is high.
  logic        a_sclk_p = 1'b0, a_cs_p = 1'b1, a_ldac_p = 1'b1;
  logic [15:0] a_acc = '0;
  int          a_cs_len = 0, a_ldac_len = 0, a_viol = 0;
  logic [15:0] a_words[$];
  int          a_cs_lens[$], a_ldac_lens[$], a_fall_q[$], a_done_q[$];

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    a_sclk_p <= a_sclk;
    a_cs_p   <= a_cs_n;
    a_ldac_p <= a_ldac_n;
    if (rst) begin
      a_acc <= '0; a_cs_len <= 0; a_ldac_len <= 0; a_viol <= 0;
      a_words.delete(); a_cs_lens.delete(); a_ldac_lens.delete();
      a_fall_q.delete(); a_done_q.delete();
    end else begin
      if (!a_cs_n && a_sclk && !a_sclk_p) a_acc <= {a_acc[14:0], a_mosi};
      if (!a_cs_n) a_cs_len <= a_cs_len + 1;
      if (!a_cs_n && a_cs_p) a_fall_q.push_back(cyc);
      if (a_cs_n && !a_cs_p) begin
        a_words.push_back(a_acc);
        a_cs_lens.push_back(a_cs_len);
        a_cs_len <= 0;
      end
      if (!a_ldac_n) a_ldac_len <= a_ldac_len + 1;
      if (a_ldac_n && !a_ldac_p) begin
        a_ldac_lens.push_back(a_ldac_len);
        a_ldac_len <= 0;
      end
      if (a_done) a_done_q.push_back(cyc);
      if (a_sclk && a_cs_n) a_viol <= a_viol + 1;
    end
  end

  logic        b_sclk_p = 1'b0, b_cs_p = 1'b1;
  logic [15:0] b_acc = '0;
  int          b_cs_len = 0, b_same = 0, b_hi = 0;
  logic [15:0] b_words[$];
  int          b_cs_lens[$], b_fall_q[$], b_done_q[$];

  always @(negedge clk) begin
    b_sclk_p <= b_sclk;
    b_cs_p   <= b_cs_n;
    if (rst) begin
      b_acc <= '0; b_cs_len <= 0; b_same <= 0; b_hi <= 0;
      b_words.delete(); b_cs_lens.delete(); b_fall_q.delete(); b_done_q.delete();
    end else begin
      if (!b_cs_n && b_sclk && !b_sclk_p) b_acc <= {b_acc[14:0], b_mosi};
      if (!b_cs_n) b_cs_len <= b_cs_len + 1;
      if (!b_cs_n && b_sclk) b_hi <= b_hi + 1;
      if (!b_cs_n && !b_cs_p && b_sclk == b_sclk_p) b_same <= b_same + 1;
      if (!b_cs_n && b_cs_p) b_fall_q.push_back(cyc);
      if (b_cs_n && !b_cs_p) begin
        b_words.push_back(b_acc);
        b_cs_lens.push_back(b_cs_len);
        b_cs_len <= 0;
      end
      if (b_done) b_done_q.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_sv = 1'b0;
    b_sv = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic strobe_a(input logic [11:0] d);
    a_sv = 1'b1;
    a_sd = d;
    tick(1);
    a_sv = 1'b0;
    a_sd = 12'($urandom);
  endtask

  task automatic strobe_b(input logic [11:0] d);
    b_sv = 1'b1;
    b_sd = d;
    tick(1);
    b_sv = 1'b0;
    b_sd = 12'($urandom);
  endtask

  task automatic wait_done_a(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (a_done_q.size() >= n) ok = 1'b1;
      else tick(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    tests++;
    if ({a_sclk, a_cs_n, a_mosi, a_ldac_n, a_busy, a_done} !== 6'b010100) begin
      fails++;
      $display("[TB] FAIL reset_pins_a: got %b want 010100", {a_sclk, a_cs_n, a_mosi, a_ldac_n, a_busy, a_done});
    end
    tests++;
    if (a_drop !== 4'd0 || b_drop !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_drop: got %0d/%0d want 0/0", a_drop, b_drop);
    end
    tests++;
    if ({b_sclk, b_cs_n, b_mosi, b_ldac_n, b_busy, b_done} !== 6'b010100) begin
      fails++;
      $display("[TB] FAIL reset_pins_b: got %b want 010100", {b_sclk, b_cs_n, b_mosi, b_ldac_n, b_busy, b_done});
    end
    rst = 1'b0;
    tick(2);
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    bit ok;
    int df;
    do_reset();
    strobe_a(12'hA5C);
    wait_done_a(1, 400, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL single_timeout: frame_done count %0d want 1", a_done_q.size());
    end
    tests++;
    if (a_words.size() != 1 || a_words[0] !== 16'h7A5C) begin
      fails++;
      $display("[TB] FAIL single_word: got %0d words first %h want 7a5c", a_words.size(), (a_words.size() > 0) ? a_words[0] : 16'hxxxx);
    end
    tests++;
    if (a_cs_lens.size() != 1 || a_cs_lens[0] != 128) begin
      fails++;
      $display("[TB] FAIL single_cs_len: got %0d want 128", (a_cs_lens.size() > 0) ? a_cs_lens[0] : -1);
    end
    tests++;
    if (a_ldac_lens.size() != 1 || a_ldac_lens[0] != 4) begin
      fails++;
      $display("[TB] FAIL single_ldac_len: got %0d want 4", (a_ldac_lens.size() > 0) ? a_ldac_lens[0] : -1);
    end
    df = (a_done_q.size() > 0 && a_fall_q.size() > 0) ? a_done_q[0] - a_fall_q[0] : -1;
    tests++;
    if (df != 136) begin
      fails++;
      $display("[TB] FAIL single_done_latency: got %0d want 136", df);
    end
    tick(1);
    tests++;
    if (a_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_busy_end: got %b want 0", a_busy);
    end
    $display("[TB] test_single word %h latency %0d", (a_words.size() > 0) ? a_words[0] : 16'hxxxx, df);
  endtask

  task automatic test_codes();
    bit ok;
    logic [11:0] codes[3];
    logic [15:0] expw[3];
    codes = '{12'd0, 12'd4095, 12'd2048};
    expw  = '{16'h7000, 16'h7FFF, 16'h7800};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      strobe_a(codes[i]);
      tick(199);
    end
    wait_done_a(3, 100, ok);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (a_words.size() <= i || a_words[i] !== expw[i]) begin
        fails++;
        $display("[TB] FAIL codes_word%0d: got %h want %h", i, (a_words.size() > i) ? a_words[i] : 16'hxxxx, expw[i]);
      end else begin
        $display("[TB] codes frame %0d word %h", i, a_words[i]);
      end
    end
    tests++;
    if (a_drop !== 4'd0 || a_viol != 0) begin
      fails++;
      $display("[TB] FAIL codes_drop_sclk: drop %0d sclk-while-cs-high %0d want 0/0", a_drop, a_viol);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int gap;
    do_reset();
    strobe_a(12'd100);
    tick(9);
    strobe_a(12'd200);
    tick(9);
    strobe_a(12'd300);
    wait_done_a(2, 500, ok);
    tests++;
    if (a_words.size() != 2 || a_words[1] !== 16'h712C || a_words[0] !== 16'h7064) begin
      fails++;
      $display("[TB] FAIL overrun_words: got %0d words last %h want 2 words 7064,712c", a_words.size(), (a_words.size() > 1) ? a_words[1] : 16'hxxxx);
    end
    tests++;
    if (a_drop !== 4'd1) begin
      fails++;
      $display("[TB] FAIL overrun_drop: got %0d want 1", a_drop);
    end
    gap = (a_fall_q.size() > 1) ? a_fall_q[1] - a_fall_q[0] : -1;
    tests++;
    if (gap != 136) begin
      fails++;
      $display("[TB] FAIL overrun_b2b: frame start spacing %0d want 136", gap);
    end
    $display("[TB] test_overrun spacing %0d drop %0d", gap, a_drop);
  endtask

  task automatic test_midframe_reset();
    bit ok;
    do_reset();
    strobe_a(12'h3C3);
    for (int i = 0; i < 20 && a_fall_q.size() == 0; i++) tick(1);
    tick(50);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({a_cs_n, a_sclk, a_busy} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL midreset_pins: cs_n,sclk,busy got %b want 100", {a_cs_n, a_sclk, a_busy});
    end
    tick(3);
    rst = 1'b0;
    tick(200);
    tests++;
    if (a_ldac_lens.size() != 0 || a_done_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL midreset_no_ldac: ldac pulses %0d done %0d want 0/0", a_ldac_lens.size(), a_done_q.size());
    end
    strobe_a(12'h5A5);
    wait_done_a(1, 400, ok);
    tests++;
    if (!ok || a_words.size() != 1 || a_words[0] !== 16'h75A5 || a_cs_lens[0] != 128) begin
      fails++;
      $display("[TB] FAIL midreset_recover: words %0d first %h want 1 word 75a5 cs 128", a_words.size(), (a_words.size() > 0) ? a_words[0] : 16'hxxxx);
    end
    $display("[TB] test_midframe_reset done");
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    strobe_a(12'd1);
    for (int i = 0; i < 21; i++) begin
      tick(1);
      strobe_a(12'(i + 2));
      if (i == 15) begin
        tests++;
        if (a_drop !== 4'd15) begin
          fails++;
          $display("[TB] FAIL sat_reach: got %0d want 15", a_drop);
        end
      end
    end
    tests++;
    if (a_drop !== 4'd15) begin
      fails++;
      $display("[TB] FAIL sat_hold: got %0d want 15", a_drop);
    end
    wait_done_a(2, 500, ok);
    tests++;
    if (a_words.size() != 2 || a_words[1] !== 16'h7016) begin
      fails++;
      $display("[TB] FAIL sat_newest: got %h want 7016", (a_words.size() > 1) ? a_words[1] : 16'hxxxx);
    end
    $display("[TB] test_saturation drop %0d", a_drop);
  endtask

  task automatic test_clkdiv1();
    bit ok;
    int df;
    do_reset();
    strobe_b(12'h001);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (b_done_q.size() >= 1) ok = 1'b1;
      else tick(1);
    end
    tests++;
    if (!ok || b_words.size() != 1 || b_words[0] !== 16'h7001) begin
      fails++;
      $display("[TB] FAIL div1_word: words %0d got %h want 7001", b_words.size(), (b_words.size() > 0) ? b_words[0] : 16'hxxxx);
    end
    df = (b_done_q.size() > 0 && b_fall_q.size() > 0) ? b_done_q[0] - b_fall_q[0] : -1;
    tests++;
    if (df != 34 || b_cs_lens.size() != 1 || b_cs_lens[0] != 32) begin
      fails++;
      $display("[TB] FAIL div1_timing: frame %0d want 34, cs low %0d want 32", df, (b_cs_lens.size() > 0) ? b_cs_lens[0] : -1);
    end
    tests++;
    if (b_same != 0 || b_hi != 16) begin
      fails++;
      $display("[TB] FAIL div1_toggle: non-toggling cycles %0d want 0, high cycles %0d want 16", b_same, b_hi);
    end
    $display("[TB] test_clkdiv1 frame %0d cycles", df);
  endtask

  // Reference model: a frame occupies 136 cycles; one pending slot, newest wins.
  task automatic test_random();
    logic [15:0] exp_q[$];
    int          m_rem, m_drop, gap;
    bit          m_pend, old_pend, sv;
    logic [11:0] m_pdata, old_data, sd;
    do_reset();
    m_rem = 0; m_drop = 0; m_pend = 1'b0; m_pdata = '0;
    gap = $urandom_range(1, 220);
    for (int c = 0; c < 6000; c++) begin
      sd = 12'($urandom);
      sv = (c < 5600) && (gap == 0);
      if (gap == 0) gap = $urandom_range(1, 220);
      else gap--;
      if (m_rem == 0) begin
        if (m_pend) begin
          exp_q.push_back({4'h7, m_pdata});
          m_rem = 136;
          if (sv) m_pdata = sd;
          else    m_pend  = 1'b0;
        end else if (sv) begin
          exp_q.push_back({4'h7, sd});
          m_rem = 136;
        end
      end else begin
        old_pend = m_pend;
        old_data = m_pdata;
        if (sv) begin
          if (m_pend && m_drop < 15) m_drop++;
          m_pend  = 1'b1;
          m_pdata = sd;
        end
        if (m_rem == 1) begin
          if (old_pend) begin
            exp_q.push_back({4'h7, old_data});
            m_rem = 136;
            if (!sv) m_pend = 1'b0;
          end else begin
            m_rem = 0;
          end
        end else begin
          m_rem--;
        end
      end
      a_sv = sv;
      a_sd = sd;
      tick(1);
    end
    a_sv = 1'b0;
    tests++;
    if (a_words.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL rand_count: got %0d frames want %0d", a_words.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < a_words.size(); i++) begin
      tests++;
      if (a_words[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL rand_word%0d: got %h want %h", i, a_words[i], exp_q[i]);
      end else begin
        $display("[TB] rand frame %0d word %h", i, a_words[i]);
      end
    end
    tests++;
    if (a_drop !== 4'(m_drop)) begin
      fails++;
      $display("[TB] FAIL rand_drop: got %0d want %0d", a_drop, m_drop);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_codes();
    test_overrun();
    test_midframe_reset();
    test_saturation();
    test_clkdiv1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Output-side counterpart of the processor's 12-bit `dac_output`.
- Captures a DAC code on each sample strobe, normally `clk_4khz_en`, and serialises it as a 16-bit SPI mode-0 frame to an external MCP4921-class DAC.
- Pulses LDAC after each frame so the analog output updates.
- Sits between `phi_n_neural_processor` and the board DAC pins.
- Holds one pending sample with newest-wins semantics and counts samples it discards.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; minimum 1.
- DAC_CFG, 4'b0111: command nibble sent ahead of the 12-bit code (A/B=0, BUF=1, GA=1, SHDN=1).
- CNT_W, 16: width of the drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- sample_valid  in  1  one-cycle strobe; tie to `clk_4khz_en`
- sample_data  in  12  unsigned DAC code; connect to `dac_output`
- dac_sclk  out  1  SPI clock, idles low
- dac_cs_n  out  1  chip select, active-low
- dac_mosi  out  1  serial data, MSB first
- dac_ldac_n  out  1  latch pulse, active-low
- busy  out  1  high while a frame or LDAC pulse is in progress
- frame_done  out  1  one-cycle pulse when the LDAC phase ends
- drop_count  out  CNT_W  saturating count of overwritten pending samples

Behaviour:
- Reset values while rst is high, effective immediately (asynchronous):
  - dac_sclk=0, dac_cs_n=1, dac_mosi=0, dac_ldac_n=1
  - busy=0, frame_done=0, drop_count=0
  - pending register empty, FSM in IDLE
- Reset asserted mid-frame aborts the frame; no partial LDAC is issued.
- Frame word is {DAC_CFG, sample_data} (16 bits), latched into the shift register when a frame starts.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, CS_GAP, LDAC. A half-period counter is reloaded with CLK_DIV-1 on each state or phase entry.
- IDLE:
  - sample_valid, or a non-empty pending register, starts a frame and moves to SETUP on the next edge.
  - Pending has priority over a simultaneous new strobe. In that case the new sample becomes pending; this is not a drop.
- SETUP (CLK_DIV cycles): dac_cs_n=0, dac_sclk=0, dac_mosi=bit15, busy=1.
- SCK_HI (CLK_DIV cycles): dac_sclk=1; the DAC samples dac_mosi on the rising edge.
  - Exit goes to SCK_LO if bits remain, otherwise to CS_GAP.
- SCK_LO (CLK_DIV cycles): dac_sclk=0; dac_mosi advances to the next bit on entry.
- Frame shape:
  - 16 high phases and 15 low phases.
  - dac_cs_n is low for exactly 32*CLK_DIV cycles.
  - dac_mosi is stable for the full high phase of each bit.
- CS_GAP (CLK_DIV cycles): dac_cs_n=1, dac_sclk=0, dac_mosi=0.
- LDAC (CLK_DIV cycles): dac_ldac_n=0. On exit:
  - frame_done=1 for one cycle.
  - If pending is non-empty, go directly to SETUP with the pending sample and clear pending.
  - Otherwise go to IDLE and drop busy.
- Total frame is 34*CLK_DIV cycles, from the first SETUP cycle to the last LDAC cycle.
- busy is high from the first SETUP cycle through the last LDAC cycle.
- sample_valid while busy:
  - Pending empty: store the sample and set pending.
  - Pending full: overwrite (newest wins) and increment drop_count. drop_count saturates at all-ones and does not wrap.
- sample_valid in the same cycle that LDAC exits: the strobe is treated as arriving while busy.
- sample_data is ignored except in a cycle where sample_valid=1.
- Throughput rule: strobe period must be at least 34*CLK_DIV cycles for lossless operation. In FAST_SIM (strobe every 10 clk) drops are expected and are not an error.

Test Plan:
- Reset, then one strobe with sample_data=12'hA5C, CLK_DIV=4:
  - At the 16 dac_sclk rising edges, dac_mosi reads 0111_1010_0101_1100.
  - dac_cs_n is low for 128 cycles; dac_ldac_n is low for 4 cycles.
  - frame_done fires 136 cycles after SETUP entry; busy returns to 0.
- Strobes every 200 cycles with codes 0, 4095, 2048:
  - Three frames carrying 0x7000, 0x7FFF, 0x7800.
  - drop_count stays 0; dac_sclk is never high while dac_cs_n=1.
- Three strobes 10 cycles apart (codes 100, 200, 300) during one frame:
  - The second frame carries 300; drop_count=1; no idle gap between LDAC exit and the second SETUP.
- Assert rst at cycle 50 of a frame:
  - Same cycle: dac_cs_n=1, dac_sclk=0, busy=0.
  - No LDAC pulse; after release, a new strobe produces a clean full frame.
- Force drop_count near saturation (CNT_W=4, 20 overwrites): the counter holds at 15.
- CLK_DIV=1 with sample 12'h001: the frame lasts 34 cycles and dac_sclk toggles every cycle. This is the timing bound for the implementation.
